cam_fifo_writer: RTL and testbench



---
 rtl/cam_fifo_writer.sv | 140 ++++++++++++++
 tb/tb_cam_fifo_writer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_fifo_writer.sv
// Write-side controller for the AL422B frame FIFO: crops one full MT9V034 frame
// per capture request to an IMG_W x IMG_H window and writes it from FIFO address 0.
module cam_fifo_writer #(
  parameter int IMG_W       = 384,
  parameter int IMG_H       = 288,
  parameter int X_START     = 184,
  parameter int Y_START     = 96,
  parameter int WRST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [7:0]  pix_data,
  output logic        fifo_wen_n,
  output logic        fifo_wrst_n,
  output logic [7:0]  fifo_din,
  output logic        busy,
  output logic        frame_done,
  output logic [16:0] pix_count,
  output logic        short_frame
);

  localparam logic [16:0] PIX_MAX = 17'(IMG_W * IMG_H);
  localparam logic [9:0]  ROW_LO  = 10'(Y_START);
  localparam logic [9:0]  ROW_HI  = 10'(Y_START + IMG_H);
  localparam logic [10:0] COL_LO  = 11'(X_START);
  localparam logic [10:0] COL_HI  = 11'(X_START + IMG_W);
  localparam logic [9:0]  ROW_SAT = 10'd1023;
  localparam logic [10:0] COL_SAT = 11'd2047;
  localparam int          WC_W    = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WRST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRST,
    SYNC,
    WAIT_FV,
    CAPTURE,
    DONE
  } state_t;

  state_t state, next_state;

  logic            fv_q, fv_qq, lv_q;
  logic [9:0]      row;
  logic [10:0]     col;
  logic [WC_W-1:0] wrst_cnt;

  logic lv_now, fv_rise, fv_fall, in_win, accept, wr;

  // Frame edges use two registered samples so frame_done lands two cycles after the pin.
  assign lv_now  = line_valid & frame_valid;
  assign fv_rise = fv_q & ~fv_qq;
  assign fv_fall = ~fv_q & fv_qq;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          next_state = WRST;
          accept     = 1'b1;
        end
      end
      WRST:    if (wrst_cnt == WC_LAST) next_state = SYNC;
      SYNC:    if (!frame_valid)        next_state = WAIT_FV;
      WAIT_FV: if (fv_rise)             next_state = CAPTURE;
      CAPTURE: if (fv_fall)             next_state = DONE;
      DONE:                             next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  always_comb begin
    in_win = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
    wr     = (state == CAPTURE) && lv_now && in_win && (pix_count < PIX_MAX) && !fv_fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Outputs are registered from next_state so the FIFO pins never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_q        <= 1'b0;
      fv_qq       <= 1'b0;
      lv_q        <= 1'b0;
      row         <= '0;
      col         <= '0;
      wrst_cnt    <= '0;
      fifo_wen_n  <= 1'b1;
      fifo_wrst_n <= 1'b1;
      fifo_din    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pix_count   <= '0;
      short_frame <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      fv_q  <= frame_valid;
      fv_qq <= fv_q;
      lv_q  <= lv_now;

      wrst_cnt    <= (state == WRST) ? wrst_cnt + 1'b1 : '0;
      fifo_wrst_n <= (next_state != WRST);
      busy        <= (next_state != IDLE);
      frame_done  <= (next_state == DONE);
      fifo_wen_n  <= ~wr;

      if (wr) begin
        fifo_din  <= pix_data;
        pix_count <= pix_count + 17'd1;
      end

      if (accept) begin
        pix_count   <= '0;
        short_frame <= 1'b0;
      end

      if (state == CAPTURE && next_state == DONE) short_frame <= (pix_count < PIX_MAX);

      if (state != CAPTURE) begin
        row <= '0;
        col <= '0;
      end else if (lv_now) begin
        if (col != COL_SAT) col <= col + 11'd1;
      end else if (lv_q) begin
        col <= '0;
        if (row != ROW_SAT) row <= row + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_cam_fifo_writer.sv
// Self-checking bench for cam_fifo_writer on a scaled-down window and synthetic
// sensor frames; expected write streams come from a window-enumeration model.
module tb_cam_fifo_writer;

  localparam int IMG_W       = 16;
  localparam int IMG_H       = 12;
  localparam int X_START     = 5;
  localparam int Y_START     = 3;
  localparam int WRST_CYCLES = 4;
  localparam int TOTAL       = IMG_W * IMG_H;

  typedef struct {
    int lw;
    int fh;
    int hb;
    int exp_n;
    bit exp_short;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture = 1'b0;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        fifo_wen_n, fifo_wrst_n, busy, frame_done, short_frame;
  logic [7:0]  fifo_din;
  logic [16:0] pix_count;

  cam_fifo_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_START(X_START), .Y_START(Y_START),
    .WRST_CYCLES(WRST_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .capture(capture), .frame_valid(frame_valid),
    .line_valid(line_valid), .pix_data(pix_data), .fifo_wen_n(fifo_wen_n),
    .fifo_wrst_n(fifo_wrst_n), .fifo_din(fifo_din), .busy(busy),
    .frame_done(frame_done), .pix_count(pix_count), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] wq[$];
  int   first_wr_cyc, done_cnt, done_cyc, wrst_low, wrst_runs, wrst_last_cyc;
  logic prev_wrst_n = 1'b1, prev_done = 1'b0;
  logic busy_at_done = 1'b0, busy_after_done = 1'b1;

  always @(negedge clk) begin
    if (!fifo_wen_n) begin
      if (wq.size() == 0) first_wr_cyc = cyc;
      wq.push_back(fifo_din);
    end
    if (!fifo_wrst_n) begin
      wrst_low++;
      wrst_last_cyc = cyc;
      if (prev_wrst_n) wrst_runs++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (prev_done) busy_after_done = busy;
    prev_wrst_n = fifo_wrst_n;
    prev_done   = frame_done;
  end

  task automatic clear_mon();
    wq.delete();
    first_wr_cyc    = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    wrst_low        = 0;
    wrst_runs       = 0;
    wrst_last_cyc   = -1;
    busy_at_done    = 1'b0;
    busy_after_done = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pixval(input int r, input int c, input int s);
    return 8'((r + c + s) & 255);
  endfunction

  function automatic bit in_window(input int r, input int c);
    return (r >= Y_START) && (r < Y_START + IMG_H) && (c >= X_START) && (c < X_START + IMG_W);
  endfunction

  // Reference: every in-window pixel in raster order, capped at one full image.
  logic [7:0] exp_q[$];
  task automatic build_model(input int lw, input int fh, input int s);
    exp_q.delete();
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < lw; c++)
        if (in_window(r, c) && exp_q.size() < TOTAL) exp_q.push_back(pixval(r, c, s));
  endtask

  int fall_cyc = -1;
  int win_cyc = -1;

  task automatic drive_frame(input int lw, input int fh, input int hb, input int s,
                             input int cap_row, input bit done_cap, input int rst_at);
    int nwin;
    nwin    = 0;
    win_cyc = -1;
    frame_valid = 1'b1;
    repeat (3) tick();
    for (int r = 0; r < fh; r++) begin
      for (int c = 0; c < lw; c++) begin
        line_valid = 1'b1;
        pix_data   = pixval(r, c, s);
        capture    = (r == cap_row) && (c == 0);
        if (in_window(r, c)) begin
          if (win_cyc < 0) win_cyc = cyc;
          nwin++;
        end
        tick();
        if (rst_at > 0 && nwin == rst_at) begin
          check("reset-mid wen low before reset", fifo_wen_n, 0);
          check("reset-mid pix_count before reset", pix_count, rst_at);
          #2 reset_n = 1'b0;
          #1;
          check("reset-mid fifo_wen_n", fifo_wen_n, 1);
          check("reset-mid fifo_wrst_n", fifo_wrst_n, 1);
          check("reset-mid fifo_din", fifo_din, 0);
          check("reset-mid busy", busy, 0);
          check("reset-mid frame_done", frame_done, 0);
          check("reset-mid pix_count", pix_count, 0);
          check("reset-mid short_frame", short_frame, 0);
          line_valid  = 1'b0;
          frame_valid = 1'b0;
          capture     = 1'b0;
          repeat (3) tick();
          reset_n = 1'b1;
          repeat (4) tick();
          return;
        end
      end
      line_valid = 1'b0;
      capture    = 1'b0;
      repeat (hb) begin
        pix_data = 8'($urandom);
        tick();
      end
    end
    capture     = 1'b0;
    frame_valid = 1'b0;
    fall_cyc    = cyc;
    repeat (2) tick();
    if (done_cap) begin
      capture = 1'b1;
      tick();
      capture = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic request();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic check_data(input string tag);
    int bad;
    bad = -1;
    check({tag, " model write count"}, wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      if (wq[i] !== exp_q[i] && bad < 0) bad = i;
    check({tag, " first bad data index"}, bad, -1);
  endtask

  task automatic check_common(input string tag, input int exp_n, input bit exp_short);
    check({tag, " writes"}, wq.size(), exp_n);
    check({tag, " pix_count"}, pix_count, exp_n);
    check({tag, " short_frame"}, short_frame, exp_short);
    check({tag, " frame_done pulses"}, done_cnt, 1);
    check({tag, " wrst_n low cycles"}, wrst_low, WRST_CYCLES);
    check({tag, " wrst_n pulses"}, wrst_runs, 1);
    check({tag, " frame_done latency"}, done_cyc - fall_cyc, 2);
  endtask

  initial begin
    vec_t vecs[8];
    int   s, lw, fh, hb;

    vecs[0] = '{32, 24, 4, 192, 1'b0};
    vecs[1] = '{32,  8, 3,  80, 1'b1};
    vecs[2] = '{18, 24, 2, 156, 1'b1};
    vecs[3] = '{21, 15, 1, 192, 1'b0};
    vecs[4] = '{20, 14, 5, 165, 1'b1};
    vecs[5] = '{ 5, 24, 2,   0, 1'b1};
    vecs[6] = '{32,  3, 4,   0, 1'b1};
    vecs[7] = '{ 6,  4, 1,   1, 1'b1};

    // Reset state
    clear_mon();
    reset_n = 1'b0;
    repeat (2) tick();
    check("reset fifo_wen_n", fifo_wen_n, 1);
    check("reset fifo_wrst_n", fifo_wrst_n, 1);
    check("reset fifo_din", fifo_din, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset pix_count", pix_count, 0);
    check("reset short_frame", short_frame, 0);
    reset_n = 1'b1;
    tick();

    // Nominal capture
    clear_mon();
    request();
    check("nominal busy on accept", busy, 1);
    repeat (8) tick();
    drive_frame(32, 24, 4, 0, -1, 1'b0, -1);
    build_model(32, 24, 0);
    check_data("nominal");
    check_common("nominal", TOTAL, 1'b0);
    check("nominal first value", (wq.size() > 0) ? int'(wq[0]) : -1, 8);
    check("nominal last value", (wq.size() > 0) ? int'(wq[wq.size()-1]) : -1, 34);
    check("nominal first write latency", first_wr_cyc - win_cyc, 1);
    check("nominal wrst high before first write", (first_wr_cyc - wrst_last_cyc >= 2) ? 1 : 0, 1);
    check("nominal fifo_din holds", fifo_din, 34);
    check("nominal busy after done", busy, 0);

    // Table-driven frame geometries, including short and empty windows
    for (int i = 0; i < 8; i++) begin
      clear_mon();
      request();
      repeat (8) tick();
      s = $urandom_range(0, 255);
      drive_frame(vecs[i].lw, vecs[i].fh, vecs[i].hb, s, -1, 1'b0, -1);
      build_model(vecs[i].lw, vecs[i].fh, s);
      check_data($sformatf("vec%0d", i));
      check_common($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_short);
    end

    // Randomized frames against the model
    for (int i = 0; i < 6; i++) begin
      lw = $urandom_range(1, 40);
      fh = $urandom_range(1, 28);
      hb = $urandom_range(1, 5);
      s  = $urandom_range(0, 255);
      clear_mon();
      request();
      repeat (8) tick();
      drive_frame(lw, fh, hb, s, -1, 1'b0, -1);
      build_model(lw, fh, s);
      check_data($sformatf("rand%0d", i));
      check_common($sformatf("rand%0d", i), exp_q.size(), exp_q.size() < TOTAL);
    end

    // Request arriving mid-frame waits for the next whole frame
    clear_mon();
    s = $urandom_range(0, 255);
    drive_frame(32, 24, 4, s, 10, 1'b0, -1);
    check("midframe no writes in partial frame", wq.size(), 0);
    check("midframe busy held", busy, 1);
    check("midframe no frame_done yet", done_cnt, 0);
    drive_frame(32, 24, 4, s, -1, 1'b0, -1);
    build_model(32, 24, s);
    check_data("midframe");
    check_common("midframe", TOTAL, 1'b0);

    // Re-trigger during CAPTURE and in the DONE cycle is ignored
    clear_mon();
    request();
    repeat (8) tick();
    s = $urandom_range(0, 255);
    drive_frame(32, 24, 4, s, 8, 1'b1, -1);
    build_model(32, 24, s);
    check_data("retrigger");
    check_common("retrigger", TOTAL, 1'b0);
    check("retrigger busy at frame_done", busy_at_done, 1);
    check("retrigger busy cycle after frame_done", busy_after_done, 0);
    repeat (10) tick();
    check("retrigger stays idle", busy, 0);
    check("retrigger no second wrst", wrst_runs, 1);

    // Stray line_valid while frame_valid is low
    clear_mon();
    request();
    repeat (8) tick();
    repeat (3) begin
      line_valid = 1'b1;
      pix_data   = 8'hFF;
      repeat (3) tick();
      line_valid = 1'b0;
      tick();
    end
    check("stray no writes", wq.size(), 0);
    drive_frame(32, 24, 4, 0, -1, 1'b0, -1);
    build_model(32, 24, 0);
    check_data("stray");
    check_common("stray", TOTAL, 1'b0);
    check("stray first value", (wq.size() > 0) ? int'(wq[0]) : -1, 8);

    // Asynchronous reset in the middle of a capture
    clear_mon();
    request();
    repeat (8) tick();
    drive_frame(32, 24, 4, 0, -1, 1'b0, 50);
    repeat (10) tick();
    check("reset-mid no frame_done", done_cnt, 0);
    check("reset-mid idle after release", busy, 0);

    clear_mon();
    request();
    repeat (8) tick();
    drive_frame(32, 24, 4, 7, -1, 1'b0, -1);
    build_model(32, 24, 7);
    check_data("post-reset");
    check_common("post-reset", TOTAL, 1'b0);
    check("post-reset first value", (wq.size() > 0) ? int'(wq[0]) : -1, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
